// File: rtl/kurm_fetch_queue.sv
// kurm_fetch_queue: fetch PC, one-cycle-latency instruction memory requests,
// and a first-word-fall-through FIFO of {instruction, pc} for the datapath.
// A redirect flushes buffered and in-flight words and restarts fetch.
module kurm_fetch_queue #(
   parameter int          DEPTH    = 4,
   parameter logic [15:0] PC_RESET = 16'h0000
) (
   input  logic                       clk,
   input  logic                       rst_n,
   output logic                       imem_req,
   output logic [15:0]                imem_addr,
   input  logic [15:0]                imem_data,
   input  logic                       redirect,
   input  logic [15:0]                redirect_pc,
   output logic                       inst_valid,
   output logic [15:0]                inst_data,
   output logic [15:0]                inst_pc,
   input  logic                       inst_ready,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [15:0] PC_START = {PC_RESET[15:1], 1'b0};

   typedef enum logic {BOOT, RUN} state_t;

   state_t          state_q, state_d;
   logic [15:0]     fpc_q, fpc_d;
   logic            inflight_q, inflight_d;
   logic [15:0]     req_pc_q, req_pc_d;
   logic [PW-1:0]   rd_q, rd_d;
   logic [PW-1:0]   wr_q, wr_d;
   logic [CW-1:0]   count_q, count_d;

   logic [15:0]     data_mem [DEPTH];
   logic [15:0]     pc_mem   [DEPTH];

   logic            req;
   logic            push;
   logic            pop;
   logic            valid;

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      next_ptr = (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // Request/handshake decode, next-state and outputs
   always_comb begin
      state_d    = state_q;
      fpc_d      = fpc_q;
      inflight_d = inflight_q;
      req_pc_d   = req_pc_q;
      rd_d       = rd_q;
      wr_d       = wr_q;
      count_d    = count_q;

      valid = (count_q != '0);
      // The pop happening this cycle is not credited toward free space.
      req   = (state_q == RUN) && !redirect &&
              ((int'(count_q) + int'(inflight_q)) < DEPTH);
      push  = inflight_q && !redirect;
      pop   = valid && inst_ready && !redirect;

      if (state_q == BOOT) begin
         state_d = RUN;
         if (redirect) begin
            fpc_d = {redirect_pc[15:1], 1'b0};
         end
      end else if (redirect) begin
         fpc_d      = {redirect_pc[15:1], 1'b0};
         inflight_d = 1'b0;
         rd_d       = '0;
         wr_d       = '0;
         count_d    = '0;
      end else begin
         if (push) begin
            wr_d = next_ptr(wr_q);
         end
         if (pop) begin
            rd_d = next_ptr(rd_q);
         end
         count_d    = count_q + CW'(push) - CW'(pop);
         inflight_d = req;
         if (req) begin
            req_pc_d = fpc_q;
            fpc_d    = fpc_q + 16'd2;
         end
      end

      imem_req   = req;
      imem_addr  = (state_q == RUN) ? fpc_q : '0;
      inst_valid = valid;
      inst_data  = valid ? data_mem[rd_q] : '0;
      inst_pc    = valid ? pc_mem[rd_q] : '0;
      count      = count_q;
   end

   // Control state register with asynchronous flush on reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= BOOT;
         fpc_q      <= PC_START;
         inflight_q <= 1'b0;
         req_pc_q   <= '0;
         rd_q       <= '0;
         wr_q       <= '0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         fpc_q      <= fpc_d;
         inflight_q <= inflight_d;
         req_pc_q   <= req_pc_d;
         rd_q       <= rd_d;
         wr_q       <= wr_d;
         count_q    <= count_d;
      end
   end

   // FIFO storage; contents are don't-care until counted as valid
   always_ff @(posedge clk) begin
      if (push) begin
         data_mem[wr_q] <= imem_data;
         pc_mem[wr_q]   <= req_pc_q;
      end
   end

endmodule

// File: tb/tb_kurm_fetch_queue.sv
// Bench for kurm_fetch_queue: queue-based reference model checked every
// cycle, plus literal expectations at the key timing points.
module tb_kurm_fetch_queue;

   localparam int          DEPTH    = 4;
   localparam logic [15:0] PC_RESET = 16'h0000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic [15:0] imem_data;
   logic        redirect;
   logic [15:0] redirect_pc;
   logic        inst_valid;
   logic [15:0] inst_data;
   logic [15:0] inst_pc;
   logic        inst_ready;
   logic [2:0]  count;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   kurm_fetch_queue #(.DEPTH(DEPTH), .PC_RESET(PC_RESET)) dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_data(imem_data),
      .redirect(redirect), .redirect_pc(redirect_pc),
      .inst_valid(inst_valid), .inst_data(inst_data), .inst_pc(inst_pc),
      .inst_ready(inst_ready), .count(count)
   );

   // synchronous instruction memory: word = address ^ A5A5, one cycle later
   logic [15:0] mem_q = 16'h0;
   always @(posedge clk) if (imem_req) mem_q <= imem_addr ^ 16'hA5A5;
   assign imem_data = mem_q;

   // reference model
   bit          mrun  = 1'b0;
   bit          minfl = 1'b0;
   logic [15:0] mfpc  = PC_RESET;
   logic [15:0] mpend = 16'h0;
   logic [31:0] mq[$];

   function automatic bit exp_req();
      return mrun && !redirect && ((mq.size() + int'(minfl)) < DEPTH);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   initial forever begin
      bit r;
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         mrun = 1'b0; minfl = 1'b0; mfpc = PC_RESET; mpend = 16'h0;
         mq.delete();
      end else begin
         r = exp_req();
         if (!mrun) begin
            mrun = 1'b1;
            if (redirect) mfpc = {redirect_pc[15:1], 1'b0};
         end else if (redirect) begin
            mq.delete();
            minfl = 1'b0;
            mfpc  = {redirect_pc[15:1], 1'b0};
         end else begin
            if (mq.size() > 0 && inst_ready) void'(mq.pop_front());
            if (minfl) mq.push_back({mpend ^ 16'hA5A5, mpend});
            minfl = r;
            if (r) begin
               mpend = mfpc;
               mfpc  = mfpc + 16'd2;
            end
         end
      end
   end

   // per-cycle comparison against the model
   initial forever begin
      @(negedge clk);
      check("m_req",   32'(imem_req),   32'(exp_req()));
      check("m_addr",  32'(imem_addr),  32'(mrun ? mfpc : 16'h0));
      check("m_valid", 32'(inst_valid), 32'(mq.size() > 0));
      check("m_data",  32'(inst_data),  (mq.size() > 0) ? 32'(mq[0][31:16]) : 32'h0);
      check("m_pc",    32'(inst_pc),    (mq.size() > 0) ? 32'(mq[0][15:0])  : 32'h0);
      check("m_count", 32'(count),      32'(mq.size()));
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_q(input int n, input string name);
      bit found = 1'b0;
      for (int k = 0; k < 20; k++) begin
         if (mq.size() == n && (n != 3 || minfl)) begin
            found = 1'b1;
            break;
         end
         cyc();
      end
      check(name, 32'(found), 32'd1);
   endtask

   initial begin
      inst_ready = 1'b1; redirect = 1'b0; redirect_pc = 16'h0; rst_n = 1'b0;
      #4;
      check("rst_req",   32'(imem_req),   32'h0);
      check("rst_valid", 32'(inst_valid), 32'h0);
      check("rst_count", 32'(count),      32'h0);
      #18 rst_n = 1'b1;                       // cycle 0 = BOOT
      @(negedge clk);                         // cycle 1
      check("c1_req",  32'(imem_req),  32'h1);
      check("c1_addr", 32'(imem_addr), 32'h0);
      @(negedge clk);                         // cycle 2
      check("c2_addr",  32'(imem_addr),  32'h2);
      check("c2_valid", 32'(inst_valid), 32'h0);
      cyc();                                  // cycle 3
      inst_ready = 1'b0;
      @(negedge clk);
      check("c3_valid", 32'(inst_valid), 32'h1);
      check("c3_pc",    32'(inst_pc),    32'h0);
      check("c3_data",  32'(inst_data),  32'hA5A5);

      // backpressure
      repeat (6) cyc();                       // cycle 9
      @(negedge clk);
      check("bp_count", 32'(count),     32'h4);
      check("bp_req",   32'(imem_req),  32'h0);
      check("bp_addr",  32'(imem_addr), 32'h8);
      cyc();
      inst_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("resume_pc",    32'(inst_pc),    32'(2 * i));
         check("resume_valid", 32'(inst_valid), 32'h1);
      end
      repeat (8) cyc();

      // redirect with three buffered and one in flight
      inst_ready = 1'b0;
      wait_q(3, "wait_cnt3");
      redirect = 1'b1; redirect_pc = 16'h0010;
      cyc();
      redirect = 1'b0;
      @(negedge clk);
      check("rd_count", 32'(count),      32'h0);
      check("rd_valid", 32'(inst_valid), 32'h0);
      check("rd_addr",  32'(imem_addr),  32'h0010);
      cyc(); cyc();
      @(negedge clk);
      check("rd_hvalid", 32'(inst_valid), 32'h1);
      check("rd_hpc",    32'(inst_pc),    32'h0010);
      check("rd_hdata",  32'(inst_data),  32'hA5B5);

      // redirect with simultaneous pop, odd target
      inst_ready = 1'b1;
      cyc(); cyc();
      redirect = 1'b1; redirect_pc = 16'h0013;
      cyc();
      redirect = 1'b0;
      @(negedge clk);
      check("rp_count", 32'(count),      32'h0);
      check("rp_valid", 32'(inst_valid), 32'h0);
      check("rp_addr",  32'(imem_addr),  32'h0012);
      cyc(); cyc();
      @(negedge clk);
      check("rp_hpc",   32'(inst_pc),   32'h0012);
      check("rp_hdata", 32'(inst_data), 32'hA5B7);

      // wrap at top of address space
      cyc();
      redirect = 1'b1; redirect_pc = 16'hFFFC;
      cyc();
      redirect = 1'b0;
      @(negedge clk);
      check("wr_a0", 32'(imem_addr), 32'hFFFC);
      @(negedge clk);
      check("wr_a1", 32'(imem_addr), 32'hFFFE);
      @(negedge clk);
      check("wr_a2",   32'(imem_addr), 32'h0000);
      check("wr_hpc",  32'(inst_pc),   32'hFFFC);
      check("wr_hdat", 32'(inst_data), 32'h5A59);

      // back-to-back redirects, last wins
      cyc();
      redirect = 1'b1; redirect_pc = 16'h0040;
      cyc();
      redirect_pc = 16'h0080;
      cyc();
      redirect = 1'b0;
      @(negedge clk);
      check("bb_addr",  32'(imem_addr), 32'h0080);
      check("bb_count", 32'(count),     32'h0);
      repeat (4) cyc();

      // asynchronous reset pulse mid-cycle with two buffered
      inst_ready = 1'b0;
      wait_q(2, "wait_cnt2");
      #2 rst_n = 1'b0;
      #1;
      check("ar_req",   32'(imem_req),   32'h0);
      check("ar_addr",  32'(imem_addr),  32'h0);
      check("ar_valid", 32'(inst_valid), 32'h0);
      check("ar_data",  32'(inst_data),  32'h0);
      check("ar_pc",    32'(inst_pc),    32'h0);
      check("ar_count", 32'(count),      32'h0);
      rst_n = 1'b1;
      inst_ready = 1'b1;
      @(negedge clk);
      check("ar_boot_req", 32'(imem_req), 32'h0);
      @(negedge clk);
      check("ar_run_req",  32'(imem_req),  32'h1);
      check("ar_run_addr", 32'(imem_addr), 32'(PC_RESET));
      repeat (3) cyc();

      // redirect during the BOOT cycle
      #2 rst_n = 1'b0;
      #1 rst_n = 1'b1;
      redirect = 1'b1; redirect_pc = 16'h0201;
      cyc();
      redirect = 1'b0;
      @(negedge clk);
      check("bt_req",  32'(imem_req),  32'h1);
      check("bt_addr", 32'(imem_addr), 32'h0200);
      repeat (5) cyc();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
